// File: rtl/datamem_responder.sv
// Word-addressed data memory with a fixed-latency load/store handshake toward the core.
// Loads win over stores in IDLE; misaligned accesses still respond on schedule, flagged.
module datamem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        DMR_Clk,
    input  logic        DMR_Reset,
    input  logic        DMR_Ready_In,
    input  logic        DMR_Valid_In,
    input  logic [31:0] DMR_Addr_InBUS,
    input  logic [2:0]  DMR_Funct3_InBUS,
    input  logic [31:0] DMR_WrData_InBUS,
    output logic        DMR_Valid_Out,
    output logic        DMR_Ready_Out,
    output logic [31:0] DMR_RdData_OutBUS,
    output logic        DMR_Misaligned_Out,
    output logic [2:0]  DMR_Internal_State
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [2:0] {
        StIdle      = 3'b000,
        StLoadWait  = 3'b001,
        StLoadResp  = 3'b010,
        StStoreWait = 3'b011,
        StStoreResp = 3'b100
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          capture;
    logic [AW+1:0] addr_q;
    logic [2:0]    funct3_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic [31:0]   mem [DEPTH_WORDS];

    // High address bits alias onto the same words.
    logic unused_addr;
    assign unused_addr = ^DMR_Addr_InBUS[31:AW+2];

    // In IDLE the live buses describe the transaction (needed for LATENCY=0); otherwise the capture.
    logic          in_idle;
    logic [AW+1:0] txn_addr;
    logic [2:0]    txn_funct3;
    logic [31:0]   txn_wdata;
    logic [AW-1:0] txn_idx;

    assign in_idle    = (state_q == StIdle);
    assign txn_addr   = in_idle ? DMR_Addr_InBUS[AW+1:0] : addr_q;
    assign txn_funct3 = in_idle ? DMR_Funct3_InBUS : funct3_q;
    assign txn_wdata  = in_idle ? DMR_WrData_InBUS : wdata_q;
    assign txn_idx    = txn_addr[AW+1:2];

    logic misaligned;
    always_comb begin
        misaligned = 1'b1;
        case (txn_funct3)
            3'b000, 3'b100: misaligned = 1'b0;
            3'b001, 3'b101: misaligned = txn_addr[0];
            3'b010:         misaligned = (txn_addr[1:0] != 2'b00);
            default:        misaligned = 1'b1;
        endcase
    end

    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_val;
    always_comb begin
        rd_word  = mem[txn_idx];
        rd_byte  = rd_word[{txn_addr[1:0], 3'b000} +: 8];
        rd_half  = txn_addr[1] ? rd_word[31:16] : rd_word[15:0];
        load_val = 32'd0;
        case (txn_funct3)
            3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  load_val = {24'd0, rd_byte};
            3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_val = {16'd0, rd_half};
            3'b010:  load_val = rd_word;
            default: load_val = 32'd0;
        endcase
    end

    // Store data is replicated across lanes; byte enables pick the addressed ones.
    logic [3:0]  wr_be;
    logic [31:0] wr_lanes;
    always_comb begin
        wr_be    = 4'b0000;
        wr_lanes = txn_wdata;
        case (txn_funct3[1:0])
            2'b00: begin
                wr_be    = 4'b0001 << txn_addr[1:0];
                wr_lanes = {4{txn_wdata[7:0]}};
            end
            2'b01: begin
                wr_be    = 4'b0011 << {txn_addr[1], 1'b0};
                wr_lanes = {2{txn_wdata[15:0]}};
            end
            2'b10:   wr_be = 4'b1111;
            default: wr_be = 4'b0000;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            StIdle: begin
                if (DMR_Ready_In) begin
                    capture = 1'b1;
                    cnt_d   = CNT_INIT;
                    state_d = (LATENCY == 0) ? StLoadResp : StLoadWait;
                end else if (DMR_Valid_In) begin
                    capture = 1'b1;
                    cnt_d   = CNT_INIT;
                    state_d = (LATENCY == 0) ? StStoreResp : StStoreWait;
                end
            end
            StLoadWait: begin
                if (cnt_q == 4'd0) state_d = StLoadResp;
                else               cnt_d   = cnt_q - 4'd1;
            end
            StStoreWait: begin
                if (cnt_q == 4'd0) state_d = StStoreResp;
                else               cnt_d   = cnt_q - 4'd1;
            end
            StLoadResp:  state_d = StIdle;
            StStoreResp: state_d = StIdle;
            default:     state_d = StIdle;
        endcase
    end

    always_ff @(posedge DMR_Clk) begin
        if (DMR_Reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_d == StLoadResp) rdata_q <= misaligned ? 32'd0 : load_val;
        end
    end

    always_ff @(posedge DMR_Clk) begin
        if (capture) begin
            addr_q   <= DMR_Addr_InBUS[AW+1:0];
            funct3_q <= DMR_Funct3_InBUS;
            wdata_q  <= DMR_WrData_InBUS;
        end
    end

    // Memory is never cleared; a reset before STORE_RESP suppresses the write.
    always_ff @(posedge DMR_Clk) begin
        if (!DMR_Reset && state_d == StStoreResp && !misaligned) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem[txn_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
            end
        end
    end

    assign DMR_Valid_Out      = (state_q == StLoadResp);
    assign DMR_Ready_Out      = (state_q == StStoreResp);
    assign DMR_Misaligned_Out = (state_q == StLoadResp || state_q == StStoreResp) && misaligned;
    assign DMR_RdData_OutBUS  = rdata_q;
    assign DMR_Internal_State = state_q;

endmodule

// File: tb/tb_datamem_responder.sv
// Bench for datamem_responder: a LATENCY=2 and a LATENCY=0 instance checked against
// a byte-array memory model with directed and randomized load/store transactions.
module tb_datamem_responder;

    localparam int LAT0 = 2;
    localparam int LAT1 = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        ready_in [2];
    logic        valid_in [2];
    logic [31:0] addr_in  [2];
    logic [2:0]  f3_in    [2];
    logic [31:0] wdata_in [2];
    logic        valid_out[2];
    logic        ready_out[2];
    logic [31:0] rdata_out[2];
    logic        mis_out  [2];
    logic [2:0]  st_out   [2];

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_b [2][4096];

    datamem_responder dut (
        .DMR_Clk           (clk),
        .DMR_Reset         (rst),
        .DMR_Ready_In      (ready_in[0]),
        .DMR_Valid_In      (valid_in[0]),
        .DMR_Addr_InBUS    (addr_in[0]),
        .DMR_Funct3_InBUS  (f3_in[0]),
        .DMR_WrData_InBUS  (wdata_in[0]),
        .DMR_Valid_Out     (valid_out[0]),
        .DMR_Ready_Out     (ready_out[0]),
        .DMR_RdData_OutBUS (rdata_out[0]),
        .DMR_Misaligned_Out(mis_out[0]),
        .DMR_Internal_State(st_out[0])
    );

    datamem_responder #(
        .DEPTH_WORDS(1024),
        .LATENCY    (LAT1)
    ) dut_l0 (
        .DMR_Clk           (clk),
        .DMR_Reset         (rst),
        .DMR_Ready_In      (ready_in[1]),
        .DMR_Valid_In      (valid_in[1]),
        .DMR_Addr_InBUS    (addr_in[1]),
        .DMR_Funct3_InBUS  (f3_in[1]),
        .DMR_WrData_InBUS  (wdata_in[1]),
        .DMR_Valid_Out     (valid_out[1]),
        .DMR_Ready_Out     (ready_out[1]),
        .DMR_RdData_OutBUS (rdata_out[1]),
        .DMR_Misaligned_Out(mis_out[1]),
        .DMR_Internal_State(st_out[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_mis(input logic [2:0] f3, input logic [31:0] a);
        case (f3)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return a[0];
            3'b010:         return a[1:0] != 2'b00;
            default:        return 1'b1;
        endcase
    endfunction

    // Model memory is a flat byte array indexed by the wrapped 12-bit byte address.
    function automatic logic [31:0] exp_load(input int u, input logic [2:0] f3,
                                             input logic [31:0] a);
        int         p;
        logic [7:0] b;
        logic [15:0] h;
        if (is_mis(f3, a)) return 32'd0;
        p = int'(a[11:0]);
        b = mem_b[u][p];
        h = {mem_b[u][p+1], b};
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'd0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'd0, h};
            default: return {mem_b[u][p+3], mem_b[u][p+2], h};
        endcase
    endfunction

    task automatic model_store(input int u, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd);
        int n;
        int p;
        if (is_mis(f3, a)) return;
        n = 1 << f3[1:0];
        p = int'(a[11:0]);
        for (int i = 0; i < n; i++) mem_b[u][p+i] = wd[8*i +: 8];
    endtask

    task automatic do_txn(input int u, input bit is_load, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input string tag);
        int          lat;
        logic [31:0] exp_d;
        logic [2:0]  wait_st;
        logic [2:0]  resp_st;
        lat     = (u == 0) ? LAT0 : LAT1;
        exp_d   = is_load ? exp_load(u, f3, a) : 32'd0;
        wait_st = is_load ? 3'b001 : 3'b011;
        resp_st = is_load ? 3'b010 : 3'b100;
        ready_in[u] = is_load;
        valid_in[u] = !is_load;
        addr_in[u]  = a;
        f3_in[u]    = f3;
        wdata_in[u] = wd;
        @(posedge clk); #1;
        // Buses are junk after the request edge; the DUT must use what it captured.
        ready_in[u] = 1'b0;
        valid_in[u] = 1'b0;
        addr_in[u]  = $urandom;
        f3_in[u]    = 3'($urandom);
        wdata_in[u] = $urandom;
        for (int k = 0; k <= lat; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (k < lat) begin
                check({tag, "/wait_strobe"}, is_load ? valid_out[u] : ready_out[u], 0);
                check({tag, "/wait_state"}, st_out[u], wait_st);
            end else begin
                check({tag, "/strobe"}, is_load ? valid_out[u] : ready_out[u], 1);
                check({tag, "/other_strobe"}, is_load ? ready_out[u] : valid_out[u], 0);
                check({tag, "/resp_state"}, st_out[u], resp_st);
                check({tag, "/misaligned"}, mis_out[u], is_mis(f3, a));
                if (is_load) check({tag, "/rdata"}, rdata_out[u], exp_d);
            end
        end
        if (!is_load) model_store(u, f3, a, wd);
        @(posedge clk); #1;
        check({tag, "/back_idle"}, st_out[u], 3'b000);
        check({tag, "/strobe_done"}, is_load ? valid_out[u] : ready_out[u], 0);
        check({tag, "/mis_done"}, mis_out[u], 0);
        if (is_load) check({tag, "/rdata_held"}, rdata_out[u], exp_d);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] old;
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            ready_in[u] = 1'b0;
            valid_in[u] = 1'b0;
            addr_in[u]  = 32'd0;
            f3_in[u]    = 3'd0;
            wdata_in[u] = 32'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            check("reset/state", st_out[u], 3'b000);
            check("reset/valid", valid_out[u], 0);
            check("reset/ready", ready_out[u], 0);
            check("reset/rdata", rdata_out[u], 32'd0);
            check("reset/mis", mis_out[u], 0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        for (int w = 0; w < 16; w++) do_txn(0, 1'b0, 3'b010, 32'(w * 4), $urandom, "init_sw");

        do_txn(0, 1'b0, 3'b010, 32'h10, 32'hDEADBEEF, "sw_10");
        do_txn(0, 1'b1, 3'b010, 32'h10, 32'h0, "lw_10");
        check("lw_10/const", rdata_out[0], 32'hDEADBEEF);
        do_txn(0, 1'b1, 3'b000, 32'h13, 32'h0, "lb_13");
        check("lb_13/const", rdata_out[0], 32'hFFFFFFDE);
        do_txn(0, 1'b1, 3'b100, 32'h13, 32'h0, "lbu_13");
        check("lbu_13/const", rdata_out[0], 32'h000000DE);
        do_txn(0, 1'b1, 3'b001, 32'h12, 32'h0, "lh_12");
        check("lh_12/const", rdata_out[0], 32'hFFFFDEAD);
        do_txn(0, 1'b0, 3'b000, 32'h11, 32'h55, "sb_11");
        do_txn(0, 1'b1, 3'b010, 32'h10, 32'h0, "lw_10b");
        check("lw_10b/const", rdata_out[0], 32'hDEAD55EF);

        do_txn(0, 1'b1, 3'b010, 32'h06, 32'h0, "lw_06_mis");
        check("lw_06_mis/const", rdata_out[0], 32'h0);
        do_txn(0, 1'b1, 3'b010, 32'h04, 32'h0, "lw_04_intact");
        do_txn(0, 1'b0, 3'b001, 32'h03, 32'hA5A5, "sh_03_mis");
        do_txn(0, 1'b1, 3'b010, 32'h00, 32'h0, "lw_00_intact");

        // Load and store requested together: load first, store served from IDLE after.
        ready_in[0] = 1'b1;
        valid_in[0] = 1'b1;
        addr_in[0]  = 32'h10;
        f3_in[0]    = 3'b010;
        @(posedge clk); #1;
        check("both/load_wait", st_out[0], 3'b001);
        ready_in[0] = 1'b0;
        addr_in[0]  = 32'h14;
        wdata_in[0] = 32'hCAFEF00D;
        @(posedge clk); #1;
        check("both/load_wait2", st_out[0], 3'b001);
        @(posedge clk); #1;
        check("both/load_strobe", valid_out[0], 1);
        check("both/load_data", rdata_out[0], 32'hDEAD55EF);
        @(posedge clk); #1;
        check("both/idle_gap", st_out[0], 3'b000);
        check("both/no_store_yet", ready_out[0], 0);
        @(posedge clk); #1;
        check("both/store_wait", st_out[0], 3'b011);
        valid_in[0] = 1'b0;
        @(posedge clk); #1;
        check("both/store_wait2", ready_out[0], 0);
        @(posedge clk); #1;
        check("both/store_strobe", ready_out[0], 1);
        model_store(0, 3'b010, 32'h14, 32'hCAFEF00D);
        @(posedge clk); #1;
        check("both/store_idle", st_out[0], 3'b000);
        do_txn(0, 1'b1, 3'b010, 32'h14, 32'h0, "both/lw_14");

        // Reset during STORE_WAIT: aborted, memory untouched.
        valid_in[0] = 1'b1;
        addr_in[0]  = 32'h20;
        f3_in[0]    = 3'b010;
        wdata_in[0] = 32'h12345678;
        @(posedge clk); #1;
        check("rst_abort/store_wait", st_out[0], 3'b011);
        valid_in[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_abort/state", st_out[0], 3'b000);
        check("rst_abort/ready", ready_out[0], 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_abort/no_strobe", ready_out[0], 0);
        end
        old = exp_load(0, 3'b010, 32'h20);
        do_txn(0, 1'b1, 3'b010, 32'h20, 32'h0, "rst_abort/lw_20");
        check("rst_abort/old_data", rdata_out[0], old);

        // LATENCY=0 instance and address aliasing.
        do_txn(1, 1'b0, 3'b010, 32'h00001010, 32'h0BADF00D, "l0/sw_alias");
        do_txn(1, 1'b1, 3'b010, 32'h00000010, 32'h0, "l0/lw_10");
        check("l0/alias_const", rdata_out[1], 32'h0BADF00D);
        for (int i = 0; i < 8; i++) begin
            a = ($urandom & 32'hFFFFF000) | 32'h10 | 32'($urandom_range(0, 3));
            do_txn(1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                   "l0/rand");
        end

        for (int i = 0; i < 40; i++) begin
            a = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63));
            do_txn(0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                   "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/datamem_responder.md
DATAMEM_RESPONDER -- requirements
Module: datamem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit memory words (power of two).
REQ-002 SHALL have parameter LATENCY, default 2: wait cycles inserted before each response (0..15).
REQ-003 SHALL have port DMR_Clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port DMR_Reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port DMR_Ready_In  input  1  load request: core ready to accept read data.
REQ-006 SHALL have port DMR_Valid_In  input  1  store request: core write data valid.
REQ-007 SHALL have port DMR_Addr_InBUS  input  32  byte address.
REQ-008 SHALL have port DMR_Funct3_InBUS  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 SHALL have port DMR_WrData_InBUS  input  32  store data, right-aligned.
REQ-010 SHALL have port DMR_Valid_Out  output  1  load response strobe to core.
REQ-011 SHALL have port DMR_Ready_Out  output  1  store completion strobe to core.
REQ-012 SHALL have port DMR_RdData_OutBUS  output  32  load data, extended per funct3.
REQ-013 SHALL have port DMR_Misaligned_Out  output  1  error strobe, coincident with response.
REQ-014 SHALL have port DMR_Internal_State  output  3  current FSM state encoding.

Function
REQ-015 SHALL implement states IDLE=000, LOAD_WAIT=001, LOAD_RESP=010, STORE_WAIT=011, STORE_RESP=100; other codes go to IDLE next cycle.
REQ-016 SHALL in IDLE, on DMR_Ready_In=1, capture address and funct3 and go to LOAD_WAIT (LOAD_RESP if LATENCY=0).
REQ-017 SHALL in IDLE, on DMR_Valid_In=1 and DMR_Ready_In=0, capture address, funct3, write data and go to STORE_WAIT (STORE_RESP if LATENCY=0).
REQ-018 SHALL give loads priority when both requests are high in IDLE; store stays pending and is served from IDLE afterwards.
REQ-019 SHALL hold a 4-bit down-counter loaded with LATENCY-1 on entry to a WAIT state; leave WAIT for RESP when counter reaches 0.
REQ-020 SHALL assert response (DMR_Valid_Out in LOAD_RESP, DMR_Ready_Out in STORE_RESP) for exactly one cycle, LATENCY+1 cycles after the request was sampled in IDLE; RESP always returns to IDLE.
REQ-021 SHALL ignore request inputs and input buses outside IDLE; captured values govern the transaction.
REQ-022 SHALL compute word index as Addr[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (wrap-around).
REQ-023 SHALL register DMR_RdData_OutBUS on the edge entering LOAD_RESP; hold it until the next load response.
REQ-024 SHALL select byte lane Addr[1:0] / halfword lane Addr[1], little-endian; B/H sign-extend, BU/HU zero-extend, W unmodified.
REQ-025 SHALL commit stores on the edge entering STORE_RESP, writing only the addressed byte lanes (SB one lane, SH two, SW four).
REQ-026 SHALL treat H/HU with Addr[0]=1, W with Addr[1:0]!=0, or funct3 011/110/111 as misaligned: response still given on schedule, read data 0, no write, DMR_Misaligned_Out=1 in the RESP cycle.
REQ-027 SHALL drive DMR_Internal_State directly from the state register.

Reset
REQ-028 SHALL, while DMR_Reset=1 at a rising edge, go to IDLE, clear counter, DMR_Valid_Out=0, DMR_Ready_Out=0, DMR_RdData_OutBUS=0, DMR_Misaligned_Out=0.
REQ-029 SHALL abort an in-flight transaction on reset: no response, no memory write if STORE_RESP not yet entered.
REQ-030 SHALL NOT clear memory contents on reset.

Verification
REQ-031 SW 0xDEADBEEF @0x10, LATENCY=2 -> DMR_Ready_Out one cycle, 3 cycles after request; then LW @0x10 -> DMR_Valid_Out at +3, RdData=0xDEADBEEF.
REQ-032 LB @0x13 and LBU @0x13 after prior store -> RdData 0xFFFFFFDE and 0x000000DE; LH @0x12 -> 0xFFFFDEAD.
REQ-033 SB 0x55 @0x11 over 0xDEADBEEF -> subsequent LW @0x10 returns 0xDEAD55EF.
REQ-034 LW @0x06 -> response on schedule, RdData=0, Misaligned=1; memory unchanged; SH @0x03 -> no write, Misaligned=1.
REQ-035 Ready_In and Valid_In both high in IDLE -> load served first, store response follows after load's RESP+IDLE; reset asserted in STORE_WAIT -> IDLE, no write, no strobe.
REQ-036 LATENCY=0 build: request in cycle t -> strobe in t+1; address 0x00001010 with DEPTH_WORDS=1024 aliases to 0x010.
